// File: rtl/pc_sequencer_pkg.sv
// pc_pkg: shared types and default vectors for the LEGv8 program-counter sequencer
package pc_pkg;
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;
    typedef enum logic [2:0] {SEL_EXC, SEL_CALL, SEL_RET, SEL_BR, SEL_INC, SEL_HOLD} sel_e;
    localparam logic [63:0] DEF_RESET_VEC = 64'h0;
    localparam logic [63:0] DEF_EXC_VEC   = 64'h0000_0000_0000_0180;
endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// ras_stack: circular return-address stack that overwrites its oldest entry when full
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/push_data_i push an address;
// pop_i pops the top; top_o current top entry; empty_o no entries;
// ovf_o sticky push-while-full; unf_o sticky pop-while-empty.
module ras_stack #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] push_data_i,
    output logic [W-1:0] top_o,
    output logic         empty_o,
    output logic         ovf_o,
    output logic         unf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] top_q, top_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, full;
    assign full    = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign top_o   = mem_q[top_q];
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;
    // A push into a full stack advances onto the oldest slot, so count saturates.
    always_comb begin
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push_i) begin
            top_d = top_q + 1'b1;
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
            ovf_d = ovf_q | full;
        end else if (pop_i) begin
            top_d = empty_o ? top_q : top_q - 1'b1;
            cnt_d = empty_o ? cnt_q : cnt_q - 1'b1;
            unf_d = unf_q | empty_o;
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[top_d] <= push_data_i;
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: LEGv8 fetch program counter with redirects, return-address stack and halt control
// Ports: clk_i/rst_ni clock and async active-low reset; pc_o/pc_valid_o fetch request,
// pc_ready_i fetch accept; exc/br/call/ret_valid_i redirects with target_i;
// halt_i/resume_i halt control; misalign_err_o one-cycle misaligned-redirect pulse;
// ras_ovf_o/ras_unf_o sticky RAS flags; halted_o sequencer is halted.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int                STEP      = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    input  logic              pc_ready_i,
    input  logic              exc_valid_i,
    input  logic              br_valid_i,
    input  logic              call_valid_i,
    input  logic              ret_valid_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic              halt_i,
    input  logic              resume_i,
    output logic              misalign_err_o,
    output logic              ras_ovf_o,
    output logic              ras_unf_o,
    output logic              halted_o
);
    state_e            state_q, state_d;
    sel_e              sel;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, tgt, ras_top;
    logic              redirect, mis, mis_q, ras_empty;
    assign pc_o           = pc_q;
    assign pc_valid_o     = state_q == S_RUN;
    assign halted_o       = state_q == S_HALT;
    assign misalign_err_o = mis_q;
    // Outside S_RUN only exceptions act. A pending halt suppresses the increment so
    // the current pc is fetched again after resume.
    always_comb begin
        pc_inc   = pc_q + ADDR_W'(STEP);
        sel      = exc_valid_i ? SEL_EXC :
                   state_q != S_RUN ? SEL_HOLD :
                   call_valid_i ? SEL_CALL :
                   ret_valid_i  ? SEL_RET  :
                   br_valid_i   ? SEL_BR   :
                   halt_i       ? SEL_HOLD :
                   pc_ready_i   ? SEL_INC  : SEL_HOLD;
        redirect = sel == SEL_CALL || sel == SEL_RET || sel == SEL_BR;
        tgt      = (sel == SEL_RET && !ras_empty) ? ras_top : target_i;
        mis      = redirect && tgt[1:0] != 2'b00;
        pc_d     = (sel == SEL_EXC || mis) ? EXC_VEC :
                   redirect ? tgt :
                   sel == SEL_INC ? pc_inc : pc_q;
        state_d  = state_q;
        if (state_q == S_BOOT) state_d = S_RUN;
        else if (state_q == S_RUN && halt_i && !redirect && sel != SEL_EXC) state_d = S_HALT;
        else if (state_q == S_HALT && resume_i) state_d = S_RUN;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VEC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis;
        end
    end
    ras_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (sel == SEL_CALL),
        .pop_i      (sel == SEL_RET),
        .push_data_i(pc_inc),
        .top_o      (ras_top),
        .empty_o    (ras_empty),
        .ovf_o      (ras_ovf_o),
        .unf_o      (ras_unf_o)
    );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc, target;
    logic        pc_valid, pc_ready, exc_valid, br_valid, call_valid, ret_valid;
    logic        halt, resume, misalign_err, ras_ovf, ras_unf, halted;
    typedef struct {
        string       nm;
        logic [68:0] v;
    } exp_t;
    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic        e_ovf = 1'b0;
    logic        e_unf = 1'b0;
    localparam logic [6:0] R = 7'b1000000, E = 7'b0100000, B = 7'b0010000, C = 7'b0001000;
    localparam logic [6:0] T = 7'b0000100, H = 7'b0000010, U = 7'b0000001;

    pc_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_o(pc), .pc_valid_o(pc_valid), .pc_ready_i(pc_ready),
        .exc_valid_i(exc_valid), .br_valid_i(br_valid), .call_valid_i(call_valid),
        .ret_valid_i(ret_valid), .target_i(target), .halt_i(halt), .resume_i(resume),
        .misalign_err_o(misalign_err), .ras_ovf_o(ras_ovf), .ras_unf_o(ras_unf), .halted_o(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [68:0] got, input logic [68:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got pc=%h valid/halted/mis/ovf/unf=%b, expected pc=%h valid/halted/mis/ovf/unf=%b",
                     nm, got[68:5], got[4:0], exp[68:5], exp[4:0]);
        end
    endtask

    task automatic go(input string nm, input logic [6:0] ctl, input logic [63:0] tgt,
                      input logic [63:0] p, input logic v, input logic h, input logic m);
        {pc_ready, exc_valid, br_valid, call_valid, ret_valid, halt, resume} = ctl;
        target = tgt;
        sb.push_back('{nm, {p, v, h, m, e_ovf, e_unf}});
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk(e.nm, {pc, pc_valid, halted, misalign_err, ras_ovf, ras_unf}, e.v);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0;
        {pc_ready, exc_valid, br_valid, call_valid, ret_valid, halt, resume} = '0;
        target = '0;
        repeat (2) @(negedge clk);
        chk("reset", {pc, pc_valid, halted, misalign_err, ras_ovf, ras_unf}, {64'h0, 5'b00000});
        rst_n = 1'b1;
        go("boot",      R, 0, 64'h0,  1, 0, 0);
        go("inc_4",     R, 0, 64'h4,  1, 0, 0);
        go("inc_8",     R, 0, 64'h8,  1, 0, 0);
        go("inc_c",     R, 0, 64'hc,  1, 0, 0);
        go("inc_10",    R, 0, 64'h10, 1, 0, 0);
        for (int i = 0; i < 3; i++) go("stall", 0, 0, 64'h10, 1, 0, 0);
        go("br_stall",  B, 64'h200, 64'h200, 1, 0, 0);
        go("br_100",    R | B, 64'h100, 64'h100, 1, 0, 0);
        go("call_400",  R | C, 64'h400, 64'h400, 1, 0, 0);
        go("ret_104",   R | T, 0, 64'h104, 1, 0, 0);
        go("inc_108",   R, 0, 64'h108, 1, 0, 0);
        go("call_1000", R | C, 64'h1000, 64'h1000, 1, 0, 0);
        go("call_2000", R | C, 64'h2000, 64'h2000, 1, 0, 0);
        go("call_3000", R | C, 64'h3000, 64'h3000, 1, 0, 0);
        go("call_4000", R | C, 64'h4000, 64'h4000, 1, 0, 0);
        e_ovf = 1'b1;
        go("call_ovf",  R | C, 64'h5000, 64'h5000, 1, 0, 0);
        go("ret_4004",  R | T, 0, 64'h4004, 1, 0, 0);
        go("ret_3004",  R | T, 0, 64'h3004, 1, 0, 0);
        go("ret_2004",  R | T, 0, 64'h2004, 1, 0, 0);
        go("ret_1004",  R | T, 0, 64'h1004, 1, 0, 0);
        e_unf = 1'b1;
        go("ret_empty", R | T, 64'h800, 64'h800, 1, 0, 0);
        go("unf_stick", R, 0, 64'h804, 1, 0, 0);
        go("mis_br",    R | B, 64'h202, 64'h180, 1, 0, 1);
        go("mis_pulse", R, 0, 64'h184, 1, 0, 0);
        go("exc_br",    R | E | B, 64'h300, 64'h180, 1, 0, 0);
        go("inc_184",   R, 0, 64'h184, 1, 0, 0);
        go("br_20",     R | B, 64'h20, 64'h20, 1, 0, 0);
        go("halt",      R | H, 0, 64'h20, 0, 1, 0);
        go("halt_br",   R | H | B, 64'h400, 64'h20, 0, 1, 0);
        go("resume",    R | U, 0, 64'h20, 1, 0, 0);
        go("inc_24",    R, 0, 64'h24, 1, 0, 0);
        go("br_halt",   R | H | B, 64'h40, 64'h40, 1, 0, 0);
        go("halt_late", R | H, 0, 64'h40, 0, 1, 0);
        go("resume2",   R | U, 0, 64'h40, 1, 0, 0);
        go("br_top",    R | B, 64'hffff_ffff_ffff_fffc, 64'hffff_ffff_ffff_fffc, 1, 0, 0);
        go("wrap",      R, 0, 64'h0, 1, 0, 0);
        go("inc_4b",    R, 0, 64'h4, 1, 0, 0);
        go("mis_call",  R | C, 64'h501, 64'h180, 1, 0, 1);
        go("ret_8",     R | T, 0, 64'h8, 1, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst", {pc, pc_valid, halted, misalign_err, ras_ovf, ras_unf}, {64'h0, 5'b00000});
        e_ovf = 1'b0;
        e_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        go("boot2",     R, 0, 64'h0, 1, 0, 0);
        e_unf = 1'b1;
        go("ret_clr",   R | T, 64'h900, 64'h900, 1, 0, 0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
